// File: rtl/painterengine_gpu_blend_feeder.sv
// Pixel-pair feeder for the alpha-blend stage: pairs a source and a destination
// ARGB stream through small FIFOs and presents them, unpacked, with the job background.

module painterengine_gpu_blend_fifo2 (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        full_o,
   output logic        empty_o
);
   logic [31:0] mem_q [2];
   logic        wptr_q, rptr_q;
   logic [1:0]  cnt_q, cnt_d;

   // Caller guarantees push only when not full and pop only when not empty.
   assign cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (push_i) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= ~wptr_q;
         end
         if (pop_i) rptr_q <= ~rptr_q;
         cnt_q <= cnt_d;
      end
   end

   assign data_o  = mem_q[rptr_q];
   assign full_o  = (cnt_q == 2'd2);
   assign empty_o = (cnt_q == 2'd0);
endmodule

module painterengine_gpu_blend_feeder (
   input  logic        i_wire_clock,
   input  logic        i_wire_reset,
   input  logic        i_wire_start,
   input  logic [31:0] i_wire_count,
   input  logic [31:0] i_wire_background,
   input  logic [31:0] i_wire_src_data,
   input  logic        i_wire_src_valid,
   output logic        o_wire_src_ready,
   input  logic [31:0] i_wire_dst_data,
   input  logic        i_wire_dst_valid,
   output logic        o_wire_dst_ready,
   output logic        o_wire_valid,
   input  logic        i_wire_ready,
   output logic [7:0]  a1,
   output logic [7:0]  r1,
   output logic [7:0]  g1,
   output logic [7:0]  b1,
   output logic [7:0]  a2,
   output logic [7:0]  r2,
   output logic [7:0]  g2,
   output logic [7:0]  b2,
   output logic [7:0]  ba,
   output logic [7:0]  br,
   output logic [7:0]  bg,
   output logic [7:0]  bb,
   output logic        o_wire_busy,
   output logic        o_wire_done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q;
   logic [31:0] cnt_q, bg_q;
   logic [31:0] src_cnt_q, src_cnt_d, dst_cnt_q, dst_cnt_d, del_q, del_d;
   logic [31:0] src_pix_q, dst_pix_q;
   logic        valid_q;

   logic [31:0] src_head, dst_head;
   logic        src_full, src_empty, dst_full, dst_empty;
   logic        src_push, dst_push, load, deliver;

   // Accept counters cap at the latched count, so 0xFFFFFFFF never wraps.
   assign o_wire_src_ready = (state_q == RUN) && !src_full && (src_cnt_q < cnt_q);
   assign o_wire_dst_ready = (state_q == RUN) && !dst_full && (dst_cnt_q < cnt_q);
   assign src_push  = i_wire_src_valid && o_wire_src_ready;
   assign dst_push  = i_wire_dst_valid && o_wire_dst_ready;
   assign deliver   = valid_q && i_wire_ready;
   assign load      = !src_empty && !dst_empty && (!valid_q || i_wire_ready);

   assign src_cnt_d = src_cnt_q + 32'd1;
   assign dst_cnt_d = dst_cnt_q + 32'd1;
   assign del_d     = del_q + 32'd1;

   painterengine_gpu_blend_fifo2 u_src_fifo (
      .clk_i(i_wire_clock), .rst_i(i_wire_reset), .push_i(src_push), .pop_i(load),
      .data_i(i_wire_src_data), .data_o(src_head), .full_o(src_full), .empty_o(src_empty)
   );

   painterengine_gpu_blend_fifo2 u_dst_fifo (
      .clk_i(i_wire_clock), .rst_i(i_wire_reset), .push_i(dst_push), .pop_i(load),
      .data_i(i_wire_dst_data), .data_o(dst_head), .full_o(dst_full), .empty_o(dst_empty)
   );

   always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
      if (i_wire_reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bg_q      <= '0;
         src_cnt_q <= '0;
         dst_cnt_q <= '0;
         del_q     <= '0;
         src_pix_q <= '0;
         dst_pix_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (i_wire_start) begin
               cnt_q     <= i_wire_count;
               bg_q      <= i_wire_background;
               src_cnt_q <= '0;
               dst_cnt_q <= '0;
               del_q     <= '0;
               state_q   <= (i_wire_count != 32'd0) ? RUN : DONE;
            end
            RUN: begin
               if (src_push) src_cnt_q <= src_cnt_d;
               if (dst_push) dst_cnt_q <= dst_cnt_d;
               if (deliver)  del_q     <= del_d;
               if (del_q == cnt_q) state_q <= DONE;
            end
            default: state_q <= IDLE;
         endcase

         if (load) begin
            valid_q   <= 1'b1;
            src_pix_q <= src_head;
            dst_pix_q <= dst_head;
         end else if (deliver) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign o_wire_valid = valid_q;
   assign o_wire_busy  = (state_q == RUN);
   assign o_wire_done  = (state_q == DONE);

   assign {a1, r1, g1, b1} = src_pix_q;
   assign {a2, r2, g2, b2} = dst_pix_q;
   assign {ba, br, bg, bb} = bg_q;
endmodule

// File: tb/tb_painterengine_gpu_blend_feeder.sv
// Randomized bench for the blend feeder: the n-th delivered pair must be the n-th
// accepted source word with the n-th accepted destination word, plus the job background.

module tb_painterengine_gpu_blend_feeder;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] count, bkg, src_data, dst_data;
   logic        src_valid, src_ready, dst_valid, dst_ready;
   logic        o_valid, ready, busy, done;
   logic [7:0]  a1, r1, g1, b1, a2, r2, g2, b2, ba, br, bg, bb;

   painterengine_gpu_blend_feeder dut (
      .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start),
      .i_wire_count(count), .i_wire_background(bkg),
      .i_wire_src_data(src_data), .i_wire_src_valid(src_valid), .o_wire_src_ready(src_ready),
      .i_wire_dst_data(dst_data), .i_wire_dst_valid(dst_valid), .o_wire_dst_ready(dst_ready),
      .o_wire_valid(o_valid), .i_wire_ready(ready),
      .a1(a1), .r1(r1), .g1(g1), .b1(b1), .a2(a2), .r2(r2), .g2(g2), .b2(b2),
      .ba(ba), .br(br), .bg(bg), .bb(bb),
      .o_wire_busy(busy), .o_wire_done(done)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   logic [31:0] src_w [64];
   logic [31:0] dst_w [64];
   logic [31:0] jcnt, jbg;
   int unsigned nsrc, ndst, ndel, nvalid, nbusy, ndone;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] chans();
      return {a1, r1, g1, b1, a2, r2, g2, b2, ba, br, bg, bb};
   endfunction

   task automatic gen_words();
      for (int i = 0; i < 64; i++) begin
         src_w[i] = $urandom;
         dst_w[i] = $urandom;
      end
   endtask

   // Inputs for the coming edge are already applied; account for the handshakes
   // that edge will perform, then advance and check stall stability.
   task automatic tick();
      logic        stall;
      logic [95:0] snap;
      stall = o_valid && !ready;
      snap  = chans();
      if (src_valid && src_ready) begin
         chk("src_over_accept", 96'(nsrc < jcnt), 96'(1));
         nsrc++;
      end
      if (dst_valid && dst_ready) begin
         chk("dst_over_accept", 96'(ndst < jcnt), 96'(1));
         ndst++;
      end
      if (o_valid && ready) begin
         chk("pix_src", 96'({a1, r1, g1, b1}), 96'(src_w[ndel & 63]));
         chk("pix_dst", 96'({a2, r2, g2, b2}), 96'(dst_w[ndel & 63]));
         chk("pix_bg",  96'({ba, br, bg, bb}), 96'(jbg));
         ndel++;
      end
      @(posedge clk);
      #1;
      if (stall) begin
         chk("stall_valid", 96'(o_valid), 96'(1));
         chk("stall_chans", chans(), snap);
      end
      if (o_valid) nvalid++;
      if (busy)    nbusy++;
      if (done)    ndone++;
      src_data = src_w[nsrc & 63];
      dst_data = dst_w[ndst & 63];
   endtask

   function automatic logic pick(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 3) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // vs/vd: source/destination valid pattern; rm: downstream ready pattern.
   task automatic run_job(input logic [31:0] cnt, input logic [31:0] b,
                          input int vs, input int vd, input int rm, input bit restart);
      jcnt = cnt; jbg = b;
      nsrc = 0; ndst = 0; ndel = 0; nvalid = 0; nbusy = 0; ndone = 0;
      src_valid = 1'b0; dst_valid = 1'b0; ready = 1'b1;
      src_data = src_w[0]; dst_data = dst_w[0];
      start = 1'b1; count = cnt; bkg = b;
      tick();
      start = 1'b0; count = $urandom; bkg = $urandom;
      chk("busy_after_start", 96'(busy), 96'(cnt != 0));
      chk("done_after_start", 96'(done), 96'(cnt == 0));
      for (int cyc = 0; cyc < 400 && ndone == 0; cyc++) begin
         src_valid = pick(vs, cyc);
         dst_valid = pick(vd, cyc);
         ready     = (rm == 0) ? 1'b1 : (rm == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
         start     = restart && (cyc == 3);
         tick();
         start     = 1'b0;
      end
      chk("job_finished", 96'(ndone > 0), 96'(1));
      src_valid = 1'b1; dst_valid = 1'b1; ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      src_valid = 1'b0; dst_valid = 1'b0;
      chk("delivered", 96'(ndel), 96'(cnt));
      chk("src_accepts", 96'(nsrc), 96'(cnt));
      chk("dst_accepts", 96'(ndst), 96'(cnt));
      chk("done_pulses", 96'(ndone), 96'(1));
      if (cnt == 0) begin
         chk("zero_busy", 96'(nbusy), 96'(0));
         chk("zero_valid", 96'(nvalid), 96'(0));
      end else begin
         chk("busy_span", 96'(nbusy >= cnt + 1), 96'(1));
         if (vs == 0 && vd == 0 && rm == 0) begin
            chk("stream_valid_cycles", 96'(nvalid), 96'(cnt));
            chk("stream_throughput", 96'(nbusy <= cnt + 3), 96'(1));
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; count = '0; bkg = '0;
      src_data = '0; dst_data = '0; src_valid = 1'b0; dst_valid = 1'b0; ready = 1'b0;
      jcnt = '0; jbg = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", 96'({o_valid, busy, done, src_ready, dst_ready}), 96'(0));
      chk("reset_chans", chans(), 96'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      gen_words();
      src_w[0] = 32'h80C0801C;
      dst_w[0] = 32'h80574437;
      run_job(32'd1, 32'h40404040, 0, 0, 0, 1'b0);

      gen_words(); run_job(32'd16, $urandom, 0, 0, 0, 1'b0);
      gen_words(); run_job(32'd8,  $urandom, 0, 1, 1, 1'b0);
      gen_words(); run_job(32'd0,  $urandom, 0, 0, 0, 1'b0);
      gen_words(); run_job(32'd6,  $urandom, 2, 2, 2, 1'b1);
      for (int k = 0; k < 3; k++) begin
         gen_words();
         run_job(32'($urandom_range(1, 20)), $urandom, 2, 2, 2, 1'b0);
      end

      // Fill both FIFOs and the output register, then reset mid-cycle.
      gen_words();
      jcnt = 32'd8; jbg = 32'h12345678;
      nsrc = 0; ndst = 0; ndel = 0;
      src_data = src_w[0]; dst_data = dst_w[0];
      start = 1'b1; count = 32'd8; bkg = jbg;
      tick();
      start = 1'b0; src_valid = 1'b1; dst_valid = 1'b1; ready = 1'b0;
      repeat (6) tick();
      chk("pre_rst_valid", 96'(o_valid), 96'(1));
      chk("pre_rst_full", 96'({src_ready, dst_ready}), 96'(0));
      #3 rst = 1'b1;
      #1;
      chk("async_rst_ctrl", 96'({o_valid, busy, done, src_ready, dst_ready}), 96'(0));
      chk("async_rst_chans", chans(), 96'(0));
      src_valid = 1'b0; dst_valid = 1'b0; ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      gen_words(); run_job(32'd2, $urandom, 0, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/painterengine_gpu_blend_feeder.md
PAINTERENGINE_GPU_BLEND_FEEDER -- requirements
Module: painterengine_gpu_blend_feeder

Interface
REQ-001 SHALL have ports: i_wire_clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have i_wire_reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have i_wire_start  in  1  job start pulse; i_wire_count  in  32  pixel count; i_wire_background  in  32  background ARGB.
REQ-004 SHALL have i_wire_src_data  in  32  source ARGB; i_wire_src_valid  in  1; o_wire_src_ready  out  1.
REQ-005 SHALL have i_wire_dst_data  in  32  destination ARGB; i_wire_dst_valid  in  1; o_wire_dst_ready  out  1.
REQ-006 SHALL have o_wire_valid  out  1  pixel pair valid; i_wire_ready  in  1  downstream accept.
REQ-007 SHALL have a1,r1,g1,b1 (source), a2,r2,g2,b2 (destination), ba,br,bg,bb (background)  out  8 each  unpacked channels for the alpha-blend stage.
REQ-008 SHALL have o_wire_busy  out  1  job active; o_wire_done  out  1  one-cycle job completion pulse.

Function
REQ-009 SHALL unpack every 32-bit word as [31:24]=A, [23:16]=R, [15:8]=G, [7:0]=B.
REQ-010 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on i_wire_start with i_wire_count!=0; IDLE->DONE on i_wire_start with i_wire_count==0; RUN->DONE when delivered count equals latched count; DONE->IDLE unconditionally after one cycle.
REQ-011 SHALL latch i_wire_count and i_wire_background on the accepted start edge; ba/br/bg/bb SHALL hold the latched background until the next accepted start.
REQ-012 SHALL ignore i_wire_start in RUN and DONE.
REQ-013 SHALL hold o_wire_busy high in RUN only; o_wire_done high in DONE only.
REQ-014 SHALL buffer each input stream in its own 2-entry FIFO; a handshake is valid&&ready at a rising edge.
REQ-015 SHALL assert o_wire_src_ready only in RUN, with source FIFO not full and accepted-source count < latched count; same rule for o_wire_dst_ready with its own FIFO and counter.
REQ-016 SHALL load the output register, popping one entry from each FIFO, when both FIFOs are non-empty and (o_wire_valid==0 or i_wire_ready==1).
REQ-017 SHALL give minimum latency of one edge: words written into both FIFOs at edge k appear with o_wire_valid=1 after edge k+1.
REQ-018 SHALL hold o_wire_valid and all channel outputs stable while o_wire_valid==1 and i_wire_ready==0.
REQ-019 SHALL count a delivered pixel on each edge with o_wire_valid&&i_wire_ready; o_wire_valid SHALL drop after the final delivery unless a new pair loads.
REQ-020 SHALL sustain one pixel per cycle when both inputs stream continuously and i_wire_ready stays 1.
REQ-021 SHALL permit simultaneous FIFO push and pop in one cycle, including when full (pop frees the slot the same edge only for the pop; push still requires ready computed from pre-edge occupancy).
REQ-022 SHALL use 32-bit counters; count 0xFFFFFFFF SHALL complete without wrap error.
REQ-023 SHALL keep streams independent: one stream may run ahead up to 2 words (FIFO depth) plus nothing further.

Reset
REQ-024 SHALL, on i_wire_reset asserted at any time, immediately enter IDLE, empty both FIFOs, clear all counters, drive o_wire_valid, o_wire_busy, o_wire_done, both readys to 0 and all 12 channel outputs to 0.
REQ-025 SHALL resume normal operation on the first rising edge after reset deassertion; an in-flight job is discarded, not resumed.

Verification
REQ-026 Start count=1, bg=0x40404040, src 0x80C0801C, dst 0x80574437, i_wire_ready=1 -> one pixel a1=128 r1=192 g1=128 b1=28 a2=128 r2=87 g2=68 b2=55 ba..bb=64, done pulses 1 cycle.
REQ-027 Start count=16, both streams valid every cycle, ready=1 -> 16 consecutive o_wire_valid cycles, in-order pairs, busy high 17+ cycles, single done.
REQ-028 Count=8, i_wire_ready toggling 1/0, dst valid only every 3rd cycle -> outputs stable during stall, 8 pairs delivered in order, no readys after 8 accepts per stream.
REQ-029 Start with count=0 -> done next cycle, busy never high, no readys, o_wire_valid never high.
REQ-030 Reset asserted mid-job with both FIFOs full and output valid -> all outputs 0 immediately; new start count=2 afterward delivers only the 2 new pairs.
REQ-031 Start pulsed again during RUN with different count/background -> ignored; job completes with original count and background.
